// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-path PC sequencer: increment, signed branch, jump and
//            call/return through a small hardware return-address stack.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int PC_W        = 15,
    parameter int OFFSET_W    = 8,
    parameter int RESET_VEC   = 1,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = 3
) (
    input  logic                clk,
    input  logic                reset_pc_n,
    input  logic                stall,
    input  logic                incr_pc,
    input  logic                branch_en,
    input  logic [OFFSET_W-1:0] offset_value,
    input  logic                jump_en,
    input  logic                call_en,
    input  logic                ret_en,
    input  logic [PC_W-1:0]     target_addr,
    input  logic                clr_err,
    output logic [PC_W-1:0]     pc_pointer,
    output logic [DEPTH_W-1:0]  stack_depth,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                err_overflow,
    output logic                err_underflow
);

    localparam logic [PC_W-1:0]    c_reset_vec = PC_W'(RESET_VEC);
    localparam logic [DEPTH_W-1:0] c_depth_max = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] c_depth_one = DEPTH_W'(1);
    localparam logic [PC_W-1:0]    c_pc_one    = PC_W'(1);

    logic [PC_W-1:0]    r_pc;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err_ovf;
    logic               r_err_unf;
    logic [PC_W-1:0]    r_stack [STACK_DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_offset_ext;
    logic [PC_W-1:0]    w_top;

    assign w_full       = (r_depth == c_depth_max);
    assign w_empty      = (r_depth == '0);
    assign w_pc_inc     = r_pc + c_pc_one;
    assign w_offset_ext = PC_W'($signed(offset_value));
    // A push happens only when call wins arbitration and there is room.
    assign w_push       = !stall && !jump_en && call_en && !w_full;

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_depth == DEPTH_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    // Stack storage carries no reset; only entries below depth are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_push && (r_depth == DEPTH_W'(i))) begin
                r_stack[i] <= w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_pc_n) begin
        if (!reset_pc_n) begin
            r_pc      <= c_reset_vec;
            r_depth   <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (clr_err) begin
                r_err_ovf <= 1'b0;
                r_err_unf <= 1'b0;
            end
            // Error sets below come after the clear so a coincident event wins.
            if (!stall) begin
                if (jump_en) begin
                    r_pc <= target_addr;
                end else if (call_en) begin
                    if (w_full) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        r_pc    <= target_addr;
                        r_depth <= r_depth + c_depth_one;
                    end
                end else if (ret_en) begin
                    if (w_empty) begin
                        r_err_unf <= 1'b1;
                    end else begin
                        r_pc    <= w_top;
                        r_depth <= r_depth - c_depth_one;
                    end
                end else if (branch_en) begin
                    r_pc <= r_pc + w_offset_ext;
                end else if (incr_pc) begin
                    r_pc <= w_pc_inc;
                end
            end
        end
    end

    assign pc_pointer    = r_pc;
    assign stack_depth   = r_depth;
    assign stack_full    = w_full;
    assign stack_empty   = w_empty;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (default params).
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_pc_n;
    logic        stall;
    logic        incr_pc;
    logic        branch_en;
    logic [7:0]  offset_value;
    logic        jump_en;
    logic        call_en;
    logic        ret_en;
    logic [14:0] target_addr;
    logic        clr_err;
    logic [14:0] pc_pointer;
    logic [2:0]  stack_depth;
    logic        stack_full;
    logic        stack_empty;
    logic        err_overflow;
    logic        err_underflow;

    int tests_run = 0;
    int tests_failed = 0;

    pc_sequencer #(
        .PC_W(15), .OFFSET_W(8), .RESET_VEC(1), .STACK_DEPTH(4), .DEPTH_W(3)
    ) dut (
        .clk(clk), .reset_pc_n(reset_pc_n), .stall(stall), .incr_pc(incr_pc),
        .branch_en(branch_en), .offset_value(offset_value), .jump_en(jump_en),
        .call_en(call_en), .ret_en(ret_en), .target_addr(target_addr),
        .clr_err(clr_err), .pc_pointer(pc_pointer), .stack_depth(stack_depth),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; incr_pc = 0; branch_en = 0; jump_en = 0;
        call_en = 0; ret_en = 0; clr_err = 0;
    endtask

    // One clock edge; outputs are sampled 1ns later, then strobes drop.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [14:0] t);
        jump_en = 1; target_addr = t; tick(); idle();
    endtask

    task automatic do_call(input logic [14:0] t);
        call_en = 1; target_addr = t; tick(); idle();
    endtask

    task automatic do_ret();
        ret_en = 1; tick(); idle();
    endtask

    task automatic do_branch(input logic [7:0] o);
        branch_en = 1; offset_value = o; tick(); idle();
    endtask

    initial begin
        idle();
        offset_value = '0;
        target_addr  = '0;
        reset_pc_n   = 0;
        #12;
        chk("reset_pc", pc_pointer, 1);
        chk("reset_depth", stack_depth, 0);
        chk("reset_empty", stack_empty, 1);
        chk("reset_full", stack_full, 0);
        chk("reset_ovf", err_overflow, 0);
        chk("reset_unf", err_underflow, 0);
        reset_pc_n = 1;
        tick();
        chk("hold_after_release", pc_pointer, 1);

        incr_pc = 1;
        tick(); chk("incr_1", pc_pointer, 2);
        tick(); chk("incr_2", pc_pointer, 3);
        tick(); chk("incr_3", pc_pointer, 4);
        idle();
        tick(); chk("no_strobe_hold", pc_pointer, 4);

        do_jump(15'h7FFF);
        incr_pc = 1; tick(); idle();
        chk("incr_wrap", pc_pointer, 0);

        do_jump(15'h0020);
        do_branch(8'hF0); chk("branch_neg16", pc_pointer, 15'h0010);
        do_branch(8'h05); chk("branch_pos5", pc_pointer, 15'h0015);
        do_jump(15'h0000);
        do_branch(8'hFF); chk("branch_wrap_down", pc_pointer, 15'h7FFF);

        do_jump(15'h0005);
        do_call(15'h0100); chk("call1_pc", pc_pointer, 15'h0100);
        chk("call1_depth", stack_depth, 1);
        do_call(15'h0200); chk("call2_pc", pc_pointer, 15'h0200);
        chk("call2_depth", stack_depth, 2);
        do_ret(); chk("ret1_pc", pc_pointer, 15'h0101);
        chk("ret1_depth", stack_depth, 1);
        do_ret(); chk("ret2_pc", pc_pointer, 15'h0006);
        chk("ret2_empty", stack_empty, 1);

        do_ret(); chk("underflow_pc", pc_pointer, 15'h0006);
        chk("underflow_flag", err_underflow, 1);
        clr_err = 1; tick(); idle();
        chk("clr_unf", err_underflow, 0);

        // Fill: pushes 0x07, 0x11, 0x21, 0x31.
        do_call(15'h0010);
        do_call(15'h0020);
        do_call(15'h0030);
        do_call(15'h0040);
        chk("fill_depth", stack_depth, 4);
        chk("fill_full", stack_full, 1);
        do_call(15'h0300); chk("overflow_pc", pc_pointer, 15'h0040);
        chk("overflow_depth", stack_depth, 4);
        chk("overflow_flag", err_overflow, 1);
        clr_err = 1; call_en = 1; target_addr = 15'h0300; tick(); idle();
        chk("clr_vs_set_ovf", err_overflow, 1);
        chk("clr_vs_set_pc", pc_pointer, 15'h0040);

        stall = 1; clr_err = 1; call_en = 1; target_addr = 15'h0500; tick(); idle();
        chk("stall_clr_ovf", err_overflow, 0);
        stall = 1; call_en = 1; target_addr = 15'h0500; tick(); idle();
        chk("stall_pc", pc_pointer, 15'h0040);
        chk("stall_depth", stack_depth, 4);
        chk("stall_no_err", err_overflow, 0);

        do_ret(); chk("ret_top_pc", pc_pointer, 15'h0031);
        chk("ret_top_depth", stack_depth, 3);
        call_en = 1; ret_en = 1; target_addr = 15'h0080; tick(); idle();
        chk("call_beats_ret_pc", pc_pointer, 15'h0080);
        chk("call_beats_ret_depth", stack_depth, 4);
        do_ret(); chk("lifo_pc", pc_pointer, 15'h0032);

        incr_pc = 1; branch_en = 1; offset_value = 8'h05; jump_en = 1;
        target_addr = 15'h0040; tick(); idle();
        chk("prio_jump_pc", pc_pointer, 15'h0040);
        chk("prio_jump_depth", stack_depth, 3);

        do_ret();
        do_jump(15'h0010);
        chk("pre_reset_depth", stack_depth, 2);
        incr_pc = 1;
        @(posedge clk); #2;
        reset_pc_n = 0;
        #1;
        chk("async_reset_pc", pc_pointer, 1);
        chk("async_reset_depth", stack_depth, 0);
        chk("async_reset_empty", stack_empty, 1);
        idle();
        @(negedge clk);
        reset_pc_n = 1;
        tick(); chk("post_reset_hold", pc_pointer, 1);
        do_ret(); chk("post_reset_unf", err_underflow, 1);
        chk("post_reset_unf_pc", pc_pointer, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the crypto processor fetch path; generalises the fixed 15-bit PC with a 4-bit forward-only offset. Supports configurable PC width and reset vector, signed relative branch, absolute jump, and a hardware call/return stack of configurable depth with stall and error reporting. Drives the instruction-memory address each cycle from decoder control strobes.

Parameters:
PC_W, 15, program-counter width in bits; arithmetic is modulo 2^PC_W
OFFSET_W, 8, branch offset width; two's-complement signed
RESET_VEC, 1, PC value loaded on reset; truncated to PC_W
STACK_DEPTH, 4, return-address stack entries (>=1)
DEPTH_W, 3, width of stack_depth output; must satisfy 2^DEPTH_W > STACK_DEPTH

Ports:
clk  in  1  rising-edge clock
reset_pc_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and stack; all control strobes ignored
incr_pc  in  1  PC <= PC+1
branch_en  in  1  PC <= PC + sign_extend(offset_value)
offset_value  in  OFFSET_W  signed relative offset
jump_en  in  1  PC <= target_addr
call_en  in  1  push PC+1, PC <= target_addr
ret_en  in  1  pop, PC <= popped address
target_addr  in  PC_W  absolute target for jump/call
clr_err  in  1  clears sticky error flags
pc_pointer  out  PC_W  current PC (registered)
stack_depth  out  DEPTH_W  number of valid stack entries
stack_full  out  1  stack_depth == STACK_DEPTH
stack_empty  out  1  stack_depth == 0
err_overflow  out  1  sticky: call attempted while full
err_underflow  out  1  sticky: return attempted while empty

Behaviour:
- Reset (reset_pc_n low, asynchronous, any time incl. mid-operation): pc_pointer=RESET_VEC, stack_depth=0, stack_empty=1, stack_full=0, err_overflow=0, err_underflow=0. Stack contents need not be cleared. Release is synchronous to next clk edge by system design.
- All updates on rising clk; pc_pointer and status outputs are registered, visible the cycle after the strobe (latency 1).
- Per-cycle priority (one action only): stall > jump_en > call_en > ret_en > branch_en > incr_pc > hold. Lower-priority strobes asserted simultaneously are ignored, not queued.
- stall=1: PC, stack, depth held; errors not set. clr_err still honoured during stall.
- jump: PC <= target_addr; stack untouched.
- call, not full: stack[depth] <= (PC+1) mod 2^PC_W; depth+1; PC <= target_addr.
- call, full: no push, PC holds, err_overflow <= 1.
- ret, not empty: PC <= stack[depth-1]; depth-1.
- ret, empty: PC holds, err_underflow <= 1.
- branch: offset sign-extended to PC_W, added modulo 2^PC_W (wraps both directions; e.g. PC=0, offset=-1 -> all ones).
- incr: PC+1 modulo 2^PC_W; max value wraps to 0.
- No strobes: PC holds.
- Stack is LIFO; call and ret never both take effect in one cycle (priority picks call).
- Error flags are sticky until clr_err=1 (cleared next edge). If clr_err and a new error event coincide, the flag ends set (set wins).
- stack_full/stack_empty derived from registered depth; consistent with stack_depth in the same cycle.

Test Plan:
- Reset: reset_pc_n low mid-count with PC=0x0010 and depth=2 -> immediately pc_pointer=1, stack_depth=0, stack_empty=1, flags 0; holds 1 until first strobe after release.
- Increment/wrap: PC_W=15, PC=0x7FFF, incr_pc -> pc_pointer=0x0000 next cycle; incr for 3 cycles from 1 -> 2,3,4.
- Signed branch: PC=0x0020, offset=8'hF0 (-16) -> 0x0010; PC=0x0000, offset=8'hFF -> 0x7FFF; offset=8'h05 from 0x0010 -> 0x0015.
- Call/return nesting: from PC=0x0005 call 0x0100, at 0x0100 call 0x0200 -> depth=2; ret -> 0x0101; ret -> 0x0006, stack_empty=1.
- Stack errors: fill 4 entries, 5th call target 0x0300 -> PC unchanged, depth=4, err_overflow=1; empty stack then ret -> PC unchanged, err_underflow=1; clr_err -> both 0; clr_err coincident with overflowing call -> err_overflow stays 1.
- Priority/stall: incr+branch+jump together with target 0x0040 -> PC=0x0040, depth unchanged; stall=1 with call_en -> PC, depth unchanged, no error; call_en+ret_en together -> call executes.
